// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand/opcode widths and the opcode encodings
// understood by the shared ALU instance.
package alu_pkg;

    localparam int ALU_OPW = 3;
    localparam int ALU_W   = 32;

    localparam logic [ALU_OPW-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OPW-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OPW-1:0] ALU_OP2 = 3'b010;

endpackage

// File: rtl/alu_share_arb_if.sv
// Bundle of requester, ALU and response signals around alu_share_arb.
// slave = the arbiter's view; master = requesters, ALU and response consumer.
interface alu_share_arb_if
    import alu_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = ALU_W,
    parameter int OPW   = ALU_OPW
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*OPW-1:0]   req_op;

    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic [OPW-1:0]        alu_op;
    logic [WIDTH-1:0]      alu_result;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_result;

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result
    );

    modport master (
        output req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result
    );

endinterface

// File: rtl/alu_share_arb_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request after
// index `last` (wrapping modulo NREQ) wins.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            any
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        logic found;
        int   idx;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU among NREQ requesters: round-robin grant into an
// issue register (S1) driving the ALU, result captured into a response register (S2).
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = ALU_W,
    parameter int OPW   = ALU_OPW,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_share_arb_if.slave  bus
);

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_id;
    logic             any_req;
    logic             s2_load;
    logic             accept;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [OPW-1:0]   s1_op_q, s1_op_d;
    logic [IDW-1:0]   s1_id_q, s1_id_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;

    logic [IDW-1:0]   last_q, last_d;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .req      (bus.req_valid),
        .last     (last_q),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any_req)
    );

    // Gating with rst_n keeps req_ready low while reset is held, so nothing
    // is handed off that the cleared pipeline would then drop.
    always_comb begin
        s2_load = s1_valid_q && (!rsp_valid_q || bus.rsp_ready);
        accept  = rst_n && any_req && (!s1_valid_q || s2_load);
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_a_d       = s1_a_q;
        s1_b_d       = s1_b_q;
        s1_op_d      = s1_op_q;
        s1_id_d      = s1_id_q;
        last_d       = last_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = bus.req_a[int'(grant_id)*WIDTH +: WIDTH];
            s1_b_d     = bus.req_b[int'(grant_id)*WIDTH +: WIDTH];
            s1_op_d    = bus.req_op[int'(grant_id)*OPW +: OPW];
            s1_id_d    = grant_id;
            last_d     = grant_id;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = bus.alu_result;
            rsp_id_d     = s1_id_q;
        end else if (bus.rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_op_q      <= '0;
            s1_id_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= '0;
            last_q       <= IDW'(NREQ - 1);
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_op_q      <= s1_op_d;
            s1_id_q      <= s1_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
            last_q       <= last_d;
        end
    end

    assign bus.req_ready  = accept ? grant : '0;
    assign bus.alu_a      = s1_a_q;
    assign bus.alu_b      = s1_b_q;
    assign bus.alu_op     = s1_op_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_id     = rsp_id_q;

endmodule
